bin2bcd_seq: RTL
================

# bin2bcd_seq

Iterative binary-to-BCD converter (shift-add-3 / double-dabble) that feeds the four-digit seven-segment display path. A binary count enters through a valid/ready handshake, is converted one bit per clock, and the packed BCD digits are presented on a valid/ready output. The display multiplexer then scans these digits onto `anodes`/`segments`.

## Interface
- `IN_W`, 14: binary input width. Legal range is 4..16.
- `DIGITS`, 4: number of BCD output digits. `4*DIGITS` must be at least the BCD width needed for `10**DIGITS-1`.
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_bin` is valid.
- `in_ready`  out  1  block is able to accept a value; high only in IDLE.
- `in_bin`  in  IN_W  unsigned binary value.
- `out_valid`  out  1  `bcd`, `ovf` and `blank` are valid. Registered.
- `out_ready`  in  1  consumer accepts the result.
- `bcd`  out  4*DIGITS  packed BCD; digit i is `bcd[4i+3:4i]` and digit 0 is least significant.
- `ovf`  out  1  input exceeded `10**DIGITS-1`; result is saturated.
- `blank`  out  DIGITS  leading-zero mask; bit i set means digit i is blanked.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `in_bin` into the shift register and clear the BCD accumulator.
  - Set `ovf_r` = (`in_bin` > `10**DIGITS-1`) and `iter`=0.
  - Go to SHIFT.
- **SHIFT** (one iteration per edge)
  - Every accumulator digit ≥5 gets +3.
  - Then shift `{acc, bin}` left by 1 and increment `iter`.
  - On the edge where `iter`==IN_W-1, go to DONE and set `out_valid`=1.
  - `bcd` loads the final accumulator, or all 9s when `ovf_r`=1.
  - `ovf` loads `ovf_r`.
- **DONE**
  - `out_valid`=1.
  - `bcd`, `ovf` and `blank` are held stable until `out_valid && out_ready`.
  - On that edge: `out_valid`=0 and go to IDLE.
- `in_ready` is low in SHIFT and DONE. An `in_valid` asserted there is ignored and not queued.
- Width rules:
  - Accumulator is `4*DIGITS` bits; each add-3 acts on its own 4-bit digit and has no carry between digits.
  - `bcd` outputs keep their last value after a transfer until the next conversion completes.
- Reset mid-operation: conversion is aborted and no `out_valid` is produced.
- Reset values:
  - FSM=IDLE, `in_ready`=1, `out_valid`=0.
  - `bcd`=0, `ovf`=0, `blank`=0.
  - Internal registers are 0.

## Timing
- Accept edge E0 (`in_valid && in_ready`).
- SHIFT iterations occur on edges E0+1 .. E0+IN_W.
- `out_valid` is visible after edge E0+IN_W: 14 cycles for the defaults.
- With `out_ready` held at 1:
  - DONE lasts 1 cycle and IDLE is re-entered at E0+IN_W+1.
  - Next accept can occur at E0+IN_W+2.
  - Minimum period is IN_W+2 cycles.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- `BIN2BCD_BLANK_EN`
  - **Defined:** `blank` is registered together with `bcd`. Bit i = 1 when digit i and every more significant digit are 0. Bit 0 is always 0. On overflow, `blank`=0.
  - **Undefined:** `blank` is tied to 0 and no blanking logic is synthesized.

## Structure
- `bin2bcd_pkg` holds:
  - the FSM state enum (IDLE/SHIFT/DONE);
  - the `DIGITS` default;
  - a constant function returning `10**n-1` for the overflow compare;
  - the iteration counter width (`$clog2(IN_W)`).
- One sub-module, `bcd_add3`: combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times in a generate loop.

## Test plan
- `in_bin`=1234 accepted at E0 → `out_valid` after E0+14, `bcd`=16'h1234, `ovf`=0, `blank`=4'b0000.
- `in_bin`=9999 → `bcd`=16'h9999, `ovf`=0. Then `in_bin`=12000 → `bcd`=16'h9999, `ovf`=1, `blank`=0.
- `in_bin`=0 → `bcd`=16'h0000; `blank`=4'b1110 with `BIN2BCD_BLANK_EN`, 4'b0000 without. `in_bin`=42 → `blank`=4'b1100 with the macro.
- `out_ready`=0 for 5 cycles after `out_valid` → `bcd`/`ovf`/`blank`/`out_valid` stable, `in_ready`=0, and a second `in_valid` is ignored. `out_ready`=1 → transfer occurs, `in_ready`=1 next cycle.
- `reset`=1 at E0+6 during a 1234 conversion → next cycle FSM=IDLE, `out_valid`=0, `bcd`=0, `in_ready`=1. A fresh 5678 then converts to 16'h5678.
- Back-to-back stream 0..50 with `out_ready`=1 → every result correct, accepts spaced exactly 16 cycles.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_pkg
//  Description : Shared types and constants for the iterative binary-to-BCD
//                converter (FSM state enum, default digit count, constant
//                helper functions).
//  Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Default number of BCD output digits
  localparam int DIGITS_DEF = 4;

  // Largest value representable with n decimal digits (10**n - 1)
  function automatic int max_bcd(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

  // Width of the iteration counter; never narrower than one bit
  function automatic int iter_w(input int in_w);
    return (in_w <= 2) ? 1 : $clog2(in_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Combinational double-dabble correction cell. A BCD digit of
//                5 or more gets +3 so that the following left shift carries
//                correctly into the next decimal digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add 3 when the digit is 5..9 (larger codes never occur in a legal digit)
  always_comb begin
    dout = (din >= 4'd5) ? (din + 4'd3) : din;
  end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Iterative (one bit per clock) binary-to-BCD converter with
//                valid/ready handshakes on input and output. Inputs above
//                10**DIGITS-1 saturate to all nines and raise ovf.
//                Optional macro BIN2BCD_BLANK_EN enables the registered
//                leading-zero blanking mask; otherwise blank is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int                 c_acc_w = 4 * DIGITS;
  localparam int                 c_it_w  = iter_w(IN_W);
  localparam logic [31:0]        c_max   = 32'(max_bcd(DIGITS));
  localparam logic [c_acc_w-1:0] c_nines = {DIGITS{4'h9}};
  localparam logic [c_it_w-1:0]  c_last  = c_it_w'(IN_W - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_in_ready;
  logic [IN_W-1:0]      r_bin;
  logic [c_acc_w-1:0]   r_acc;
  logic [c_acc_w-1:0]   w_acc_adj;
  logic [c_acc_w-1:0]   w_acc_shift;
  logic [c_it_w-1:0]    r_iter;
  logic                 r_ovf;
  logic                 w_last;
  logic                 w_sat;
  logic                 r_out_valid;
  logic [c_acc_w-1:0]   r_bcd;
  logic                 r_ovf_out;

  // Per-digit add-3 correction applied before each shift
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (r_acc[4*gi +: 4]),
        .dout (w_acc_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Shift {acc, bin} left by one; the bit leaving the accumulator top can
  // only be set for out-of-range inputs, so it folds into saturation.
  assign w_acc_shift = {w_acc_adj[c_acc_w-2:0], r_bin[IN_W-1]};
  assign w_last      = (r_iter == c_last);
  assign w_sat       = r_ovf | w_acc_adj[c_acc_w-1];

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Conversion datapath and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin       <= '0;
      r_acc       <= '0;
      r_iter      <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_bcd       <= '0;
      r_ovf_out   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_bin  <= in_bin;
            r_acc  <= '0;
            r_iter <= '0;
            r_ovf  <= (32'(in_bin) > c_max);
          end
        end
        ST_SHIFT: begin
          r_acc  <= w_acc_shift;
          r_bin  <= {r_bin[IN_W-2:0], 1'b0};
          r_iter <= r_iter + 1'b1;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_bcd       <= w_sat ? c_nines : w_acc_shift;
            r_ovf_out   <= w_sat;
          end
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] w_zero;
  logic [DIGITS-1:0] w_run;
  logic [DIGITS-1:0] w_blank_nxt;
  logic [DIGITS-1:0] r_blank;

  // w_run[i]: digit i and every more significant digit are zero
  generate
    for (genvar gb = 0; gb < DIGITS; gb++) begin : g_blank
      assign w_zero[gb] = (w_acc_shift[4*gb +: 4] == 4'd0);
      if (gb == DIGITS - 1) begin : g_top
        assign w_run[gb] = w_zero[gb];
      end else begin : g_chain
        assign w_run[gb] = w_zero[gb] & w_run[gb+1];
      end
      if (gb == 0) begin : g_lsd
        assign w_blank_nxt[gb] = 1'b0;
      end else begin : g_upper
        assign w_blank_nxt[gb] = w_run[gb] & ~w_sat;
      end
    end
  endgenerate

  // Blank mask loads together with the BCD result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank <= '0;
    end else if (r_state == ST_SHIFT && w_last) begin
      r_blank <= w_blank_nxt;
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;
  assign ovf       = r_ovf_out;

endmodule
`default_nettype wire
